// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and default sizing for the fetch/data memory port arbiter.
package mem_port_arbiter_pkg;

   localparam int unsigned ADDR_W_DEF      = 32;
   localparam int unsigned DATA_W_DEF      = 32;
   localparam int unsigned TIMEOUT_CYC_DEF = 255;
   localparam int unsigned BE_W            = 4;

   localparam logic [BE_W-1:0] BE_WORD = 4'b1111;

   typedef enum logic [1:0] {
      ARB_IDLE   = 2'd0,
      ARB_GNT_DM = 2'd1,
      ARB_GNT_IF = 2'd2
   } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Pipeline-side request ports and memory-bus signals of the arbiter.
// The master modport is the arbiter's view; the slave modport is its environment.
interface mem_port_arbiter_if #(
   parameter int unsigned ADDR_W = mem_port_arbiter_pkg::ADDR_W_DEF,
   parameter int unsigned DATA_W = mem_port_arbiter_pkg::DATA_W_DEF
) ();

   logic              i_if_req;
   logic [ADDR_W-1:0] i_if_addr;
   logic [DATA_W-1:0] o_if_rdata;
   logic              o_if_valid;
   logic              o_if_err;
   logic              o_if_stall;

   logic              i_dm_req;
   logic              i_dm_we;
   logic [3:0]        i_dm_be;
   logic [ADDR_W-1:0] i_dm_addr;
   logic [DATA_W-1:0] i_dm_wdata;
   logic [DATA_W-1:0] o_dm_rdata;
   logic              o_dm_valid;
   logic              o_dm_err;
   logic              o_dm_stall;

   logic              o_bus_req;
   logic              o_bus_we;
   logic [3:0]        o_bus_be;
   logic [ADDR_W-1:0] o_bus_addr;
   logic [DATA_W-1:0] o_bus_wdata;
   logic              i_bus_ready;
   logic [DATA_W-1:0] i_bus_rdata;
   logic              i_bus_err;
   logic              o_timeout;

   modport master (
      input  i_if_req, i_if_addr,
      output o_if_rdata, o_if_valid, o_if_err, o_if_stall,
      input  i_dm_req, i_dm_we, i_dm_be, i_dm_addr, i_dm_wdata,
      output o_dm_rdata, o_dm_valid, o_dm_err, o_dm_stall,
      output o_bus_req, o_bus_we, o_bus_be, o_bus_addr, o_bus_wdata,
      input  i_bus_ready, i_bus_rdata, i_bus_err,
      output o_timeout
   );

   modport slave (
      output i_if_req, i_if_addr,
      input  o_if_rdata, o_if_valid, o_if_err, o_if_stall,
      output i_dm_req, i_dm_we, i_dm_be, i_dm_addr, i_dm_wdata,
      input  o_dm_rdata, o_dm_valid, o_dm_err, o_dm_stall,
      input  o_bus_req, o_bus_we, o_bus_be, o_bus_addr, o_bus_wdata,
      output i_bus_ready, i_bus_rdata, i_bus_err,
      input  o_timeout
   );

endinterface

// File: rtl/mem_port_arbiter_watchdog.sv
// Per-transfer wait counter; flags the wait cycle that reaches TIMEOUT_CYC (0 disables it).
module mem_port_arbiter_watchdog
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expired_c
);

   localparam int unsigned CNT_W = (TIMEOUT_CYC == 0) ? 1 : $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYC);
   localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYC == 0) ? '0 : CNT_W'(TIMEOUT_CYC - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (i_clr) begin
         cnt_d = '0;
      end else if (i_en && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // The current wait cycle is the TIMEOUT_CYC-th one when TIMEOUT_CYC-1 have already elapsed.
   assign o_expired_c = (TIMEOUT_CYC != 0) && i_en && (cnt_q == CNT_LAST);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory bus between the fetch and load/store ports: data has priority, one transfer
// in flight, registered bus outputs, one-cycle completion pulses with error/timeout reporting.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W      = ADDR_W_DEF,
   parameter int unsigned DATA_W      = DATA_W_DEF,
   parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
   input logic                i_clk,
   input logic                i_rst,
   mem_port_arbiter_if.master io
);

   arb_state_e        state_q, state_d;
   logic              bus_req_q, bus_req_d;
   logic              bus_we_q, bus_we_d;
   logic [BE_W-1:0]   bus_be_q, bus_be_d;
   logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
   logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
   logic              if_valid_q, if_valid_d;
   logic              if_err_q, if_err_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic              dm_valid_q, dm_valid_d;
   logic              dm_err_q, dm_err_d;
   logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
   logic              timeout_q, timeout_d;

   logic dm_elig, if_elig, xfer_done, wd_clr, wd_en, wd_expired;

   // A port whose completion pulse is out this cycle is still retiring its old request.
   assign dm_elig   = io.i_dm_req & ~dm_valid_q;
   assign if_elig   = io.i_if_req & ~if_valid_q;
   assign xfer_done = bus_req_q & io.i_bus_ready;
   assign wd_clr    = (state_q == ARB_IDLE);
   assign wd_en     = (state_q != ARB_IDLE) & bus_req_q & ~io.i_bus_ready;

   mem_port_arbiter_watchdog #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_watchdog (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_clr       (wd_clr),
      .i_en        (wd_en),
      .o_expired_c (wd_expired)
   );

   always_comb begin
      state_d     = state_q;
      bus_req_d   = bus_req_q;
      bus_we_d    = bus_we_q;
      bus_be_d    = bus_be_q;
      bus_addr_d  = bus_addr_q;
      bus_wdata_d = bus_wdata_q;
      if_valid_d  = 1'b0;
      if_err_d    = if_err_q;
      if_rdata_d  = if_rdata_q;
      dm_valid_d  = 1'b0;
      dm_err_d    = dm_err_q;
      dm_rdata_d  = dm_rdata_q;
      timeout_d   = timeout_q;

      unique case (state_q)
         ARB_IDLE: begin
            if (dm_elig) begin
               state_d     = ARB_GNT_DM;
               bus_req_d   = 1'b1;
               bus_we_d    = io.i_dm_we;
               bus_be_d    = io.i_dm_be;
               bus_addr_d  = io.i_dm_addr;
               bus_wdata_d = io.i_dm_wdata;
            end else if (if_elig) begin
               state_d     = ARB_GNT_IF;
               bus_req_d   = 1'b1;
               bus_we_d    = 1'b0;
               bus_be_d    = BE_WORD;
               bus_addr_d  = io.i_if_addr;
               bus_wdata_d = '0;
            end
         end
         ARB_GNT_DM, ARB_GNT_IF: begin
            if (xfer_done) begin
               state_d   = ARB_IDLE;
               bus_req_d = 1'b0;
               if (state_q == ARB_GNT_DM) begin
                  dm_valid_d = 1'b1;
                  dm_err_d   = io.i_bus_err;
                  if (!bus_we_q) begin
                     dm_rdata_d = io.i_bus_rdata;
                  end
               end else begin
                  if_valid_d = 1'b1;
                  if_err_d   = io.i_bus_err;
                  if_rdata_d = io.i_bus_rdata;
               end
            end else if (wd_expired) begin
               // No ready within the budget: retire the transfer as an error with zero data.
               state_d   = ARB_IDLE;
               bus_req_d = 1'b0;
               timeout_d = 1'b1;
               if (state_q == ARB_GNT_DM) begin
                  dm_valid_d = 1'b1;
                  dm_err_d   = 1'b1;
                  dm_rdata_d = '0;
               end else begin
                  if_valid_d = 1'b1;
                  if_err_d   = 1'b1;
                  if_rdata_d = '0;
               end
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q     <= ARB_IDLE;
         bus_req_q   <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_be_q    <= '0;
         bus_addr_q  <= '0;
         bus_wdata_q <= '0;
         if_valid_q  <= 1'b0;
         if_err_q    <= 1'b0;
         if_rdata_q  <= '0;
         dm_valid_q  <= 1'b0;
         dm_err_q    <= 1'b0;
         dm_rdata_q  <= '0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         bus_req_q   <= bus_req_d;
         bus_we_q    <= bus_we_d;
         bus_be_q    <= bus_be_d;
         bus_addr_q  <= bus_addr_d;
         bus_wdata_q <= bus_wdata_d;
         if_valid_q  <= if_valid_d;
         if_err_q    <= if_err_d;
         if_rdata_q  <= if_rdata_d;
         dm_valid_q  <= dm_valid_d;
         dm_err_q    <= dm_err_d;
         dm_rdata_q  <= dm_rdata_d;
         timeout_q   <= timeout_d;
      end
   end

   assign io.o_bus_req   = bus_req_q;
   assign io.o_bus_we    = bus_we_q;
   assign io.o_bus_be    = bus_be_q;
   assign io.o_bus_addr  = bus_addr_q;
   assign io.o_bus_wdata = bus_wdata_q;
   assign io.o_if_valid  = if_valid_q;
   assign io.o_if_err    = if_err_q;
   assign io.o_if_rdata  = if_rdata_q;
   assign io.o_dm_valid  = dm_valid_q;
   assign io.o_dm_err    = dm_err_q;
   assign io.o_dm_rdata  = dm_rdata_q;
   assign io.o_timeout   = timeout_q;
   assign io.o_if_stall  = io.i_if_req & ~if_valid_q;
   assign io.o_dm_stall  = io.i_dm_req & ~dm_valid_q;

endmodule
